m_mc_ctrl: RTL and testbench

Multi-cycle sequencing controller for the five-stage RISC-V datapath (IF/ID/EX/MA/WB). It replaces the free-running PC update and the always-on register-file and data-memory strobes with per-stage enables. Each instruction takes 3–5 cycles plus any memory wait, with a ready handshake on data memory, a halt request, and an MA watchdog. It sits beside the datapath, decodes `w_opcode5` (IR[6:2]), and drives the PC, IR, RF and DMEM write/read enables.

---
 rtl/m_mc_ctrl_if.sv | 32 +++
 rtl/m_mc_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_m_mc_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/m_mc_ctrl_if.sv
// Control bus between the multi-cycle sequencer and the five-stage datapath.
// The master side is the sequencer: it consumes decode/handshake inputs and
// produces the per-stage enables and status.
interface m_mc_ctrl_if #(
    parameter int CW = 32
);
    logic [4:0]    w_opcode5;
    logic          w_dmem_rdy;
    logic          w_halt_req;
    logic          w_pc_we;
    logic          w_ir_we;
    logic          w_rf_we;
    logic          w_dmem_re;
    logic          w_dmem_we;
    logic          w_wb_sel_ld;
    logic [2:0]    w_state;
    logic          w_halted;
    logic          w_err;
    logic [CW-1:0] w_icnt;

    modport master (
        input  w_opcode5, w_dmem_rdy, w_halt_req,
        output w_pc_we, w_ir_we, w_rf_we, w_dmem_re, w_dmem_we, w_wb_sel_ld,
        output w_state, w_halted, w_err, w_icnt
    );

    modport slave (
        output w_opcode5, w_dmem_rdy, w_halt_req,
        input  w_pc_we, w_ir_we, w_rf_we, w_dmem_re, w_dmem_we, w_wb_sel_ld,
        input  w_state, w_halted, w_err, w_icnt
    );
endinterface

// File: rtl/m_mc_ctrl.sv
// Multi-cycle sequencing controller for the IF/ID/EX/MA/WB datapath.
// Steps one instruction at a time through the stages, issuing PC/IR/RF/DMEM
// enables decoded from the state register and the current opcode class.
// Data-memory accesses wait on a ready handshake guarded by a watchdog;
// a halt request is honoured only at instruction boundaries.
module m_mc_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 32
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    m_mc_ctrl_if.master bus
);

    // Wait counter holds 0..TIMEOUT-1 while an access is outstanding.
    localparam int             WCW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit             WD_EN     = (TIMEOUT > 0);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MA   = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_RST  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        C_WR = 2'd0,
        C_LD = 2'd1,
        C_ST = 2'd2,
        C_BR = 2'd3
    } cls_t;

    state_t         state_q;
    state_t         state_d;
    state_t         bnd_next;
    cls_t           cls;
    logic [WCW-1:0] wait_q;
    logic           wait_clr;
    logic           wait_inc;
    logic           err_q;
    logic           err_set;
    logic [CW-1:0]  icnt_q;

    logic pc_we;
    logic ir_we;
    logic rf_we;
    logic dmem_re;
    logic dmem_we;
    logic wb_sel_ld;

    // Opcode class decode from IR[6:2]; everything not LD/ST/BR writes a register.
    always_comb begin
        cls = C_WR;
        case (bus.w_opcode5)
            5'b00000: cls = C_LD;
            5'b01000: cls = C_ST;
            5'b11000: cls = C_BR;
            default:  cls = C_WR;
        endcase
    end

    // Instruction boundary: a pending halt request parks the sequencer.
    always_comb begin
        bnd_next = bus.w_halt_req ? S_HALT : S_IF;
    end

    // Next-state and strobe decode; strobes are pure functions of state and class.
    always_comb begin
        state_d   = S_RST;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        wb_sel_ld = 1'b0;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        err_set   = 1'b0;
        case (state_q)
            S_RST: state_d = S_IF;
            S_IF: begin
                ir_we   = 1'b1;
                state_d = S_ID;
            end
            S_ID: state_d = S_EX;
            S_EX: begin
                case (cls)
                    C_LD, C_ST: begin
                        wait_clr = 1'b1;
                        state_d  = S_MA;
                    end
                    C_BR: begin
                        pc_we   = 1'b1;
                        state_d = bnd_next;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MA: begin
                dmem_re = (cls == C_LD);
                dmem_we = (cls == C_ST);
                // Ready wins over the watchdog on the same edge.
                if (bus.w_dmem_rdy) begin
                    if (cls == C_ST) begin
                        pc_we   = 1'b1;
                        state_d = bnd_next;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (WD_EN && (wait_q == WAIT_LAST)) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_inc = 1'b1;
                    state_d  = S_MA;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                wb_sel_ld = (cls == C_LD);
                state_d   = bnd_next;
            end
            S_HALT: begin
                // A watchdog error pins the sequencer here until reset.
                state_d = (err_q || bus.w_halt_req) ? S_HALT : S_IF;
            end
            default: state_d = S_RST;
        endcase
    end

    // State register.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // MA wait counter: cleared on entry to MA, saturating while ready is low.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wait_q <= '0;
        end else if (wait_clr) begin
            wait_q <= '0;
        end else if (wait_inc && (wait_q != {WCW{1'b1}})) begin
            wait_q <= wait_q + WCW'(1);
        end
    end

    // Sticky watchdog error, cleared only by reset.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    // Retired-instruction count: one per PC update, wrapping.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            icnt_q <= '0;
        end else if (pc_we) begin
            icnt_q <= icnt_q + CW'(1);
        end
    end

    assign bus.w_pc_we     = pc_we;
    assign bus.w_ir_we     = ir_we;
    assign bus.w_rf_we     = rf_we;
    assign bus.w_dmem_re   = dmem_re;
    assign bus.w_dmem_we   = dmem_we;
    assign bus.w_wb_sel_ld = wb_sel_ld;
    assign bus.w_state     = state_q;
    assign bus.w_halted    = (state_q == S_HALT);
    assign bus.w_err       = err_q;
    assign bus.w_icnt      = icnt_q;

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Directed bench for m_mc_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle output trace and a compare loop
// checks every cycle; literal checks pin key points.
module tb_m_mc_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b01000;
    localparam logic [4:0] OP_BR   = 5'b11000;
    localparam logic [4:0] OP_ADDI = 5'b00100;

    // Strobe bit order: {ir_we, pc_we, rf_we, dmem_re, dmem_we, wb_sel_ld}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] IR   = 6'b100000;
    localparam logic [5:0] PC   = 6'b010000;
    localparam logic [5:0] RF   = 6'b001000;
    localparam logic [5:0] RE   = 6'b000100;
    localparam logic [5:0] WE   = 6'b000010;
    localparam logic [5:0] SEL  = 6'b000001;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    m_mc_ctrl_if #(.CW(CW)) bus ();

    m_mc_ctrl #(.TIMEOUT(TO), .CW(CW)) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          m_icnt = 0;
    logic        m_err  = 1'b0;
    logic        chk_en = 1'b0;
    logic [10:0] exp_vec;
    logic [CW-1:0] exp_icnt;

    function automatic logic [5:0] act_stb();
        return {bus.w_ir_we, bus.w_pc_we, bus.w_rf_we,
                bus.w_dmem_re, bus.w_dmem_we, bus.w_wb_sel_ld};
    endfunction

    function automatic logic [10:0] act_vec();
        return {bus.w_state, act_stb(), bus.w_halted, bus.w_err};
    endfunction

    task automatic chk_lit(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    endtask

    // Per-cycle comparison against the model's expectation for this cycle.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_chk++;
                if (act_vec() === exp_vec) n_pass++;
                else $display("FAIL cycle_out t=%0t actual(st,stb,hlt,err)=%b required=%b",
                              $time, act_vec(), exp_vec);
                n_chk++;
                if (bus.w_icnt === exp_icnt) n_pass++;
                else $display("FAIL cycle_icnt t=%0t actual=%0d required=%0d",
                              $time, bus.w_icnt, exp_icnt);
            end
        end
    endtask

    // One clock cycle: drive inputs, publish expected outputs, advance the model.
    task automatic step(input logic [2:0] st, input logic [5:0] stb,
                        input logic rdy, input logic halt);
        bus.w_dmem_rdy = rdy;
        bus.w_halt_req = halt;
        exp_vec  = {st, stb, (st == 3'd5), m_err};
        exp_icnt = CW'(m_icnt);
        chk_en   = 1'b1;
        @(posedge clk);
        #1;
        if (stb[4]) m_icnt = (m_icnt + 1) % (1 << CW);
    endtask

    // Expand one instruction into its cycles from its class.
    // hmode: 0 no halt, 1 halt_req high from ID through the boundary, 2 pulse in ID only.
    // rdy is held high outside MA to show it has no effect there.
    task automatic run_instr(input logic [4:0] opc, input int nwait, input int hmode);
        logic h_id;
        logic h_mid;
        logic [5:0] acc;
        h_id  = (hmode != 0);
        h_mid = (hmode == 1);
        acc   = (opc == OP_LD) ? RE : WE;
        bus.w_opcode5 = opc;
        step(3'd0, IR, 1'b1, 1'b0);
        step(3'd1, NONE, 1'b1, h_id);
        if (opc == OP_BR) begin
            step(3'd2, PC, 1'b1, h_mid);
        end else if (opc == OP_LD || opc == OP_ST) begin
            step(3'd2, NONE, 1'b1, h_mid);
            if (nwait >= TO) begin
                for (int i = 0; i < TO; i++) step(3'd3, acc, 1'b0, h_mid);
                m_err = 1'b1;
            end else begin
                for (int i = 0; i < nwait; i++) step(3'd3, acc, 1'b0, h_mid);
                if (opc == OP_ST) begin
                    step(3'd3, WE | PC, 1'b1, h_mid);
                end else begin
                    step(3'd3, RE, 1'b1, h_mid);
                    step(3'd4, RF | PC | SEL, 1'b1, h_mid);
                end
            end
        end else begin
            step(3'd2, NONE, 1'b1, h_mid);
            step(3'd4, RF | PC, 1'b1, h_mid);
        end
    endtask

    initial begin
        fork
            compare_loop();
        join_none

        bus.w_opcode5  = OP_ADDI;
        bus.w_dmem_rdy = 1'b0;
        bus.w_halt_req = 1'b0;
        exp_vec  = {3'd7, NONE, 1'b0, 1'b0};
        exp_icnt = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_lit("reset_state", 32'(bus.w_state), 32'd7);
        chk_lit("reset_strobes", 32'(act_stb()), 32'd0);
        chk_lit("reset_icnt_err_halted", {bus.w_icnt, bus.w_err, bus.w_halted}, 32'd0);
        chk_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(3'd7, NONE, 1'b0, 1'b0);

        // addi: 7,0,1,2,4,0
        run_instr(OP_ADDI, 0, 0);
        chk_lit("addi_icnt", 32'(bus.w_icnt), 32'd1);
        chk_lit("addi_back_in_if", 32'(bus.w_state), 32'd0);

        // lw with two wait cycles, then sw, then beq
        run_instr(OP_LD, 2, 0);
        chk_lit("lw_icnt", 32'(bus.w_icnt), 32'd2);
        run_instr(OP_ST, 0, 0);
        chk_lit("sw_icnt", 32'(bus.w_icnt), 32'd3);
        run_instr(OP_BR, 0, 0);
        chk_lit("beq_icnt", 32'(bus.w_icnt), 32'd4);

        // Halt pulse that misses the boundary is ignored
        run_instr(OP_ADDI, 0, 2);
        chk_lit("pulse_ignored_state", 32'(bus.w_state), 32'd0);

        // Ready arriving on the last allowed MA cycle still succeeds
        run_instr(OP_LD, TO - 1, 0);
        run_instr(OP_ST, TO - 1, 0);
        chk_lit("rdy_at_limit_err", 32'(bus.w_err), 32'd0);
        chk_lit("rdy_at_limit_icnt", 32'(bus.w_icnt), 32'd7);

        // Halt requested in ID: instruction finishes, then park
        run_instr(OP_ADDI, 0, 1);
        step(3'd5, NONE, 1'b0, 1'b1);
        step(3'd5, NONE, 1'b1, 1'b1);
        chk_lit("halt_state", 32'(bus.w_state), 32'd5);
        chk_lit("halt_halted", 32'(bus.w_halted), 32'd1);
        chk_lit("halt_icnt", 32'(bus.w_icnt), 32'd8);
        step(3'd5, NONE, 1'b0, 1'b0);
        chk_lit("halt_release", 32'(bus.w_state), 32'd0);

        // Eight branches take the 4-bit counter from 8 round to 0
        for (int i = 0; i < 8; i++) run_instr(OP_BR, 0, 0);
        chk_lit("icnt_wrap", 32'(bus.w_icnt), 32'd0);

        // Reset asserted in WB kills the pending write without a clock edge
        bus.w_opcode5 = OP_ADDI;
        step(3'd0, IR, 1'b1, 1'b0);
        step(3'd1, NONE, 1'b1, 1'b0);
        step(3'd2, NONE, 1'b1, 1'b0);
        chk_en = 1'b0;
        #1;
        chk_lit("wb_strobes_before_rst", 32'(act_stb()), 32'(RF | PC));
        rst_n = 1'b0;
        #1;
        chk_lit("midwb_rst_state", 32'(bus.w_state), 32'd7);
        chk_lit("midwb_rst_strobes", 32'(act_stb()), 32'd0);
        chk_lit("midwb_rst_icnt", 32'(bus.w_icnt), 32'd0);
        m_icnt = 0;
        m_err  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(3'd7, NONE, 1'b0, 1'b0);

        // Watchdog: lw never gets ready -> HALT with sticky error
        run_instr(OP_LD, TO, 0);
        step(3'd5, NONE, 1'b0, 1'b0);
        step(3'd5, NONE, 1'b0, 1'b1);
        step(3'd5, NONE, 1'b1, 1'b0);
        chk_lit("wd_state", 32'(bus.w_state), 32'd5);
        chk_lit("wd_err", 32'(bus.w_err), 32'd1);
        chk_lit("wd_icnt", 32'(bus.w_icnt), 32'd0);

        // Asynchronous reset between edges clears everything at once
        chk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_lit("async_rst_state", 32'(bus.w_state), 32'd7);
        chk_lit("async_rst_err_halted", {bus.w_err, bus.w_halted}, 32'd0);
        chk_lit("async_rst_strobes", 32'(act_stb()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
